// File: rtl/apb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_pkg                                                          |
// | Brief    : Shared widths, register-map constants, FSM states and address    |
// |            legality check for the APB master bridge.                        |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package apb_pkg;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;
    localparam int STRB_W   = 4;
    localparam logic [ADDR_W-1:0] REG_STRIDE = 16'h0040;
    localparam int NUM_REGS = 16;

    localparam int OFS_W = $clog2(REG_STRIDE);
    localparam int IDX_W = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // Register-aligned and inside the NUM_REGS window.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
        return (addr[OFS_W-1:0] == '0) && (addr[ADDR_W-1:OFS_W+IDX_W] == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_master_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_master_bridge_if                                             |
// | Brief    : Command/response port and APB4 bus of the master bridge.         |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface apb_master_bridge_if
    import apb_pkg::*;
;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strb;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [STRB_W-1:0] PSTRB;
    logic              PREADY;
    logic [DATA_W-1:0] PRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  rsp_ready, PREADY, PRDATA,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output rsp_ready, PREADY, PRDATA,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );

endinterface
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_wait_timer                                                   |
// | Brief    : Counts ACCESS wait cycles; flags the wait that reaches the limit.|
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module apb_wait_timer #(
    parameter int TIMEOUT_CYC = 8
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clear_i,
    input  wire logic inc_i,
    output logic      expired_o
);

    localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Asserted during the wait cycle whose closing edge makes the count hit the limit.
    assign expired_o = inc_i && (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_master_bridge                                                |
// | Brief    : Single-outstanding APB4 requester with valid/ready cmd/rsp ports.|
// |            Optional ACCESS timeout enabled by macro APB_TIMEOUT_EN.         |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 8
) (
    input  wire logic           PCLK,
    input  wire logic           PRESETn,
    apb_master_bridge_if.master bus
);

    apb_state_e        state_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [STRB_W-1:0] pstrb_q;

    logic              w_timer_expired;

`ifdef APB_TIMEOUT_EN
    // SETUP always precedes ACCESS, so clearing there restarts the count on entry.
    apb_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk       (PCLK),
        .rst_n     (PRESETn),
        .clear_i   (state_q == SETUP),
        .inc_i     ((state_q == ACCESS) && !bus.PREADY),
        .expired_o (w_timer_expired)
    );
`else
    logic w_unused_timeout;
    assign w_timer_expired  = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYC == 0);
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_ready_q && bus.cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        if (addr_legal(bus.cmd_addr)) begin
                            state_q   <= SETUP;
                            psel_q    <= 1'b1;
                            penable_q <= 1'b0;
                            paddr_q   <= bus.cmd_addr;
                            pwrite_q  <= bus.cmd_write;
                            pwdata_q  <= bus.cmd_wdata;
                            pstrb_q   <= bus.cmd_write ? bus.cmd_strb : '0;
                        end else begin
                            // Rejected locally: the bus stays untouched.
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end
                    end
                end

                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end

                ACCESS: begin
                    // Completion takes priority over a timeout expiring on the same edge.
                    if (bus.PREADY) begin
                        state_q     <= RESP;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= pwrite_q ? '0 : bus.PRDATA;
                    end else if (w_timer_expired) begin
                        state_q     <= RESP;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.PSELx     = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PSTRB     = pstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_apb_master_bridge                                             |
// | Brief    : Directed plus random transfers against a register-map model.     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_apb_master_bridge;
    import apb_pkg::*;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;

    apb_master_bridge_if bus ();

    apb_master_bridge #(
        .TIMEOUT_CYC (8)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [16];
    logic [31:0] slv_mem [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_legal(input logic [15:0] a);
        return ((a % 16'h0040) == 16'h0000) && (a < 16'h0400);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    task automatic wait_cmd_ready();
        int n;
        n = 0;
        @(negedge PCLK);
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        chk("cmd_ready_idle", bus.cmd_ready, 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_psel"},    bus.PSELx,     0);
        chk({tag, "_penable"}, bus.PENABLE,   0);
        chk({tag, "_pwrite"},  bus.PWRITE,    0);
        chk({tag, "_paddr"},   bus.PADDR,     0);
        chk({tag, "_pwdata"},  bus.PWDATA,    0);
        chk({tag, "_pstrb"},   bus.PSTRB,     0);
        chk({tag, "_rvalid"},  bus.rsp_valid, 0);
        chk({tag, "_rerr"},    bus.rsp_err,   0);
        chk({tag, "_rdata"},   bus.rsp_rdata, 0);
        chk({tag, "_cready"},  bus.cmd_ready, 0);
    endtask

    task automatic drive_cmd(input logic wr, input logic [15:0] addr,
                             input logic [31:0] wd, input logic [3:0] strb);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        bus.cmd_strb  = strb;
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = 16'($urandom);
        bus.cmd_wdata = $urandom;
        bus.cmd_strb  = 4'($urandom);
    endtask

    task automatic bus_stable(input string tag, input logic wr, input logic [15:0] addr,
                              input logic [31:0] wd, input logic [3:0] exp_strb,
                              input logic exp_en);
        chk({tag, "_psel"},    bus.PSELx,     1);
        chk({tag, "_penable"}, bus.PENABLE,   32'(exp_en));
        chk({tag, "_paddr"},   bus.PADDR,     32'(addr));
        chk({tag, "_pwrite"},  bus.PWRITE,    32'(wr));
        chk({tag, "_pwdata"},  bus.PWDATA,    wd);
        chk({tag, "_pstrb"},   bus.PSTRB,     32'(exp_strb));
        chk({tag, "_rvalid"},  bus.rsp_valid, 0);
        chk({tag, "_cready"},  bus.cmd_ready, 0);
    endtask

    task automatic finish_rsp(input logic [31:0] exp_rd, input logic exp_err, input int hold);
        for (int h = 0; h < hold; h++) begin
            bus.rsp_ready = 1'b0;
            @(negedge PCLK);
            chk("hold_valid",  bus.rsp_valid, 1);
            chk("hold_rdata",  bus.rsp_rdata, exp_rd);
            chk("hold_err",    bus.rsp_err,   32'(exp_err));
            chk("hold_cready", bus.cmd_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge PCLK);
        bus.rsp_ready = 1'b0;
        chk("post_valid",  bus.rsp_valid, 0);
        chk("post_cready", bus.cmd_ready, 1);
    endtask

    task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb, input int waits, input int hold);
        logic        legal;
        logic [3:0]  idx;
        logic [3:0]  exp_strb;
        logic [31:0] exp_rd;
        legal    = ref_legal(addr);
        idx      = addr[9:6];
        exp_strb = wr ? strb : 4'h0;
        wait_cmd_ready();
        if (bus.cmd_ready !== 1'b1) return;
        drive_cmd(wr, addr, wd, strb);
        if (!legal) begin
            chk("ill_valid", bus.rsp_valid, 1);
            chk("ill_err",   bus.rsp_err,   1);
            chk("ill_rdata", bus.rsp_rdata, 0);
            chk("ill_psel",  bus.PSELx,     0);
            finish_rsp(32'h0, 1'b1, hold);
            chk("ill_psel_end", bus.PSELx, 0);
            return;
        end
        bus_stable("setup", wr, addr, wd, exp_strb, 1'b0);
        // PREADY outside ACCESS must be ignored.
        bus.PREADY = 1'($urandom);
        bus.PRDATA = $urandom;
        @(negedge PCLK);
        for (int w = 0; w <= waits; w++) begin
            bus_stable("access", wr, addr, wd, exp_strb, 1'b1);
            bus.PREADY = (w == waits);
            bus.PRDATA = (w == waits && !wr) ? slv_mem[idx] : $urandom;
            if (w == waits && wr) slv_mem[idx] = merge(slv_mem[idx], bus.PWDATA, bus.PSTRB);
            @(negedge PCLK);
        end
        bus.PREADY = 1'($urandom);
        bus.PRDATA = $urandom;
        exp_rd = wr ? 32'h0 : ref_mem[idx];
        if (wr) ref_mem[idx] = merge(ref_mem[idx], wd, strb);
        chk("done_valid",   bus.rsp_valid, 1);
        chk("done_err",     bus.rsp_err,   0);
        chk("done_rdata",   bus.rsp_rdata, exp_rd);
        chk("done_psel",    bus.PSELx,     0);
        chk("done_penable", bus.PENABLE,   0);
        finish_rsp(exp_rd, 1'b0, hold);
    endtask

    task automatic reset_mid();
        wait_cmd_ready();
        drive_cmd(1'b1, 16'h0080, 32'hA5A5A5A5, 4'hF);
        bus.PREADY = 1'b0;
        @(negedge PCLK);
        chk("rst_pre_penable", bus.PENABLE, 1);
        #2 PRESETn = 1'b0;
        #1 check_all_zero("rst_async");
        @(negedge PCLK);
        PRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            chk("rst_no_rsp",  bus.rsp_valid, 0);
            chk("rst_no_psel", bus.PSELx,     0);
        end
        chk("rst_cready", bus.cmd_ready, 1);
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic timeout_txn();
        wait_cmd_ready();
        drive_cmd(1'b0, 16'h0140, 32'h0, 4'h0);
        bus.PREADY = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge PCLK);
            chk("to_psel",    bus.PSELx,     1);
            chk("to_penable", bus.PENABLE,   1);
            chk("to_rvalid",  bus.rsp_valid, 0);
        end
        @(negedge PCLK);
        chk("to_valid", bus.rsp_valid, 1);
        chk("to_err",   bus.rsp_err,   1);
        chk("to_rdata", bus.rsp_rdata, 0);
        chk("to_psel0", bus.PSELx,     0);
        finish_rsp(32'h0, 1'b1, 0);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        logic        wr;
        logic [15:0] addr;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = (i == 4) ? 32'h12345678 : 32'h01010101 * i;
            slv_mem[i] = ref_mem[i];
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.rsp_ready = 1'b0;
        bus.PREADY    = 1'b0;
        bus.PRDATA    = '0;
        #1 check_all_zero("reset");
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;

        do_txn(1'b1, 16'h0040, 32'hDEADBEEF, 4'hF, 2, 0);
        do_txn(1'b1, 16'h03C0, 32'hCAFEF00D, 4'b0101, 1, 1);
        do_txn(1'b0, 16'h0100, 32'h0, 4'hF, 0, 0);
        do_txn(1'b0, 16'h0040, 32'h0, 4'h0, 1, 0);
        do_txn(1'b0, 16'h03C0, 32'h0, 4'h0, 0, 0);
        do_txn(1'b1, 16'h0044, 32'h11111111, 4'hF, 0, 0);
        do_txn(1'b0, 16'h0400, 32'h0, 4'h0, 0, 2);
        do_txn(1'b0, 16'h0100, 32'h0, 4'h0, 3, 5);
        reset_mid();
`ifdef APB_TIMEOUT_EN
        timeout_txn();
`endif

        for (int t = 0; t < 150; t++) begin
            wr = 1'($urandom);
            if ($urandom_range(0, 9) < 7) addr = 16'($urandom_range(0, 15)) * 16'h0040;
            else                          addr = 16'($urandom);
            do_txn(wr, addr, $urandom, 4'($urandom), $urandom_range(0, 4), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
